// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, data and shared-memory handshake bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data_out;
    logic        imem_ready;

    logic        dmem_req;
    logic        dmem_wr;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_data_out;
    logic        dmem_ready;

    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_re;
    logic        mem_wr;
    logic [31:0] mem_data_out;
    logic        mem_ready;

    // Arbiter side: owns the memory bus, serves the two requesters.
    modport master (
        input  imem_req,
        input  imem_addr,
        output imem_data_out,
        output imem_ready,
        input  dmem_req,
        input  dmem_wr,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_data_out,
        output dmem_ready,
        output mem_addr,
        output mem_data_in,
        output mem_re,
        output mem_wr,
        input  mem_data_out,
        input  mem_ready
    );

    modport slave (
        output imem_req,
        output imem_addr,
        input  imem_data_out,
        input  imem_ready,
        output dmem_req,
        output dmem_wr,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_data_out,
        input  dmem_ready,
        input  mem_addr,
        input  mem_data_in,
        input  mem_re,
        input  mem_wr,
        output mem_data_out,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-access memory port between instruction fetch
//            and data load/store; data wins ties. Define ARB_STARVE_GUARD_EN
//            to let fetch win a tie after STARVE_LIMIT data grants.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_mem_addr;
    logic [31:0] w_mem_addr_next;
    logic [31:0] r_mem_data_in;
    logic [31:0] w_mem_data_in_next;
    logic        r_mem_re;
    logic        w_mem_re_next;
    logic        r_mem_wr;
    logic        w_mem_wr_next;
    logic        r_sel_data;
    logic        w_sel_data_next;
    logic [31:0] r_imem_data;
    logic [31:0] w_imem_data_next;
    logic [31:0] r_dmem_data;
    logic [31:0] w_dmem_data_next;
    logic        r_imem_ready;
    logic        w_imem_ready_next;
    logic        r_dmem_ready;
    logic        w_dmem_ready_next;

    logic        w_fetch_override;
    logic        w_grant_d;
    logic        w_grant_i;

    // Tie-break: data owns the port unless fetch has been starved long enough.
    assign w_grant_d = (r_state == IDLE) && bus.dmem_req
                       && !(bus.imem_req && w_fetch_override);
    assign w_grant_i = (r_state == IDLE) && bus.imem_req && !w_grant_d;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    assign w_fetch_override = (r_starve_cnt >= c_starve_limit);

    // Counts data grants taken while a fetch was waiting; saturates at 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_i) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_d && bus.imem_req && (r_starve_cnt != 4'hF)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`else
    localparam int c_unused_starve_limit = STARVE_LIMIT;

    assign w_fetch_override = 1'b0;
`endif

    always_comb begin
        w_state_next       = r_state;
        w_mem_addr_next    = r_mem_addr;
        w_mem_data_in_next = r_mem_data_in;
        w_mem_re_next      = r_mem_re;
        w_mem_wr_next      = r_mem_wr;
        w_sel_data_next    = r_sel_data;
        w_imem_data_next   = r_imem_data;
        w_dmem_data_next   = r_dmem_data;
        w_imem_ready_next  = 1'b0;
        w_dmem_ready_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next       = DACC;
                    w_mem_addr_next    = bus.dmem_addr;
                    w_mem_data_in_next = bus.dmem_wdata;
                    w_mem_re_next      = ~bus.dmem_wr;
                    w_mem_wr_next      = bus.dmem_wr;
                    w_sel_data_next    = 1'b1;
                end else if (w_grant_i) begin
                    w_state_next       = IACC;
                    w_mem_addr_next    = bus.imem_addr;
                    w_mem_data_in_next = 32'd0;
                    w_mem_re_next      = 1'b1;
                    w_mem_wr_next      = 1'b0;
                    w_sel_data_next    = 1'b0;
                end
            end

            IACC, DACC: begin
                // Everything was latched at grant, so requester inputs are ignored here.
                if (bus.mem_ready) begin
                    w_state_next  = DONE;
                    w_mem_re_next = 1'b0;
                    w_mem_wr_next = 1'b0;
                    if (r_sel_data) begin
                        w_dmem_ready_next = 1'b1;
                        if (!r_mem_wr) begin
                            w_dmem_data_next = bus.mem_data_out;
                        end
                    end else begin
                        w_imem_ready_next = 1'b1;
                        w_imem_data_next  = bus.mem_data_out;
                    end
                end
            end

            DONE: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next  = IDLE;
                w_mem_re_next = 1'b0;
                w_mem_wr_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_mem_addr    <= 32'd0;
            r_mem_data_in <= 32'd0;
            r_mem_re      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_sel_data    <= 1'b0;
            r_imem_data   <= 32'd0;
            r_dmem_data   <= 32'd0;
            r_imem_ready  <= 1'b0;
            r_dmem_ready  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_mem_addr    <= w_mem_addr_next;
            r_mem_data_in <= w_mem_data_in_next;
            r_mem_re      <= w_mem_re_next;
            r_mem_wr      <= w_mem_wr_next;
            r_sel_data    <= w_sel_data_next;
            r_imem_data   <= w_imem_data_next;
            r_dmem_data   <= w_dmem_data_next;
            r_imem_ready  <= w_imem_ready_next;
            r_dmem_ready  <= w_dmem_ready_next;
        end
    end

    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_data_in   = r_mem_data_in;
    assign bus.mem_re        = r_mem_re;
    assign bus.mem_wr        = r_mem_wr;
    assign bus.imem_data_out = r_imem_data;
    assign bus.imem_ready    = r_imem_ready;
    assign bus.dmem_data_out = r_dmem_data;
    assign bus.dmem_ready    = r_dmem_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Random requesters and a wait-state memory against a
//            transaction-level model of the fetch/data port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 = port free, 1 = access on the bus, 2 = completion being reported.
    int          phase;
    bit          g_d;
    bit          g_wr;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    int unsigned wait_left;
    int          starve;
    logic [31:0] m_idata;
    logic [31:0] m_ddata;
    logic [31:0] mem_model [logic [31:0]];

    bit          i_active;
    bit          d_active;
    int unsigned i_rate;
    int unsigned d_rate;
    int unsigned wr_rate;
    int unsigned max_wait;
    int unsigned force_wait;
    bit          force_en;
    bit          spurious_en;
    bit          drop_en;
    bit          hold_both;

    bit          inj_i;
    bit          inj_d;
    bit          inj_d_wr;
    logic [31:0] inj_i_addr;
    logic [31:0] inj_d_addr;
    logic [31:0] inj_d_wdata;

    int step_no;
    int t_inj_i;
    int t_start;
    int t_iready;
    int t_dready;
    int obs_wr_cycles;
    int obs_iready;
    int obs_dready;
    bit prev_busy;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F0F};
    endfunction

    function automatic logic [31:0] rand_addr();
        return $urandom_range(0, 31) << 2;
    endfunction

    task automatic decide();
        bit pick_i;
        if (phase == 0 && (bus.imem_req || bus.dmem_req)) begin
            if (bus.imem_req && bus.dmem_req) begin
`ifdef ARB_STARVE_GUARD_EN
                pick_i = (starve >= STARVE_LIMIT);
`else
                pick_i = 1'b0;
`endif
            end else begin
                pick_i = bus.imem_req;
            end
            if (pick_i) begin
                g_d = 1'b0; g_wr = 1'b0; g_addr = bus.imem_addr; g_wdata = 32'd0;
                starve = 0;
            end else begin
                g_d = 1'b1; g_wr = bus.dmem_wr; g_addr = bus.dmem_addr; g_wdata = bus.dmem_wdata;
                if (bus.imem_req && starve < 15) starve++;
            end
            wait_left = force_en ? force_wait : $urandom_range(0, max_wait);
            phase = 1;
        end
    endtask

    task automatic step();
        int          old_phase;
        logic [31:0] rdata;
        @(negedge clk);
        step_no++;
        old_phase = phase;

        check_value("imem_ready", 32'(bus.imem_ready), 32'(phase == 2 && !g_d));
        check_value("dmem_ready", 32'(bus.dmem_ready), 32'(phase == 2 && g_d));
        check_value("ready_overlap", 32'(bus.imem_ready & bus.dmem_ready), 32'd0);
        check_value("imem_data_out", bus.imem_data_out, m_idata);
        check_value("dmem_data_out", bus.dmem_data_out, m_ddata);
        check_value("mem_re", 32'(bus.mem_re), 32'(phase == 1 && !g_wr));
        check_value("mem_wr", 32'(bus.mem_wr), 32'(phase == 1 && g_wr));
        if (phase == 1) begin
            check_value("mem_addr", bus.mem_addr, g_addr);
            if (g_wr) check_value("mem_data_in", bus.mem_data_in, g_wdata);
        end

        if (bus.mem_wr) obs_wr_cycles++;
        if (bus.imem_ready) begin obs_iready++; t_iready = step_no; end
        if (bus.dmem_ready) begin obs_dready++; t_dready = step_no; end
        if ((bus.mem_re || bus.mem_wr) && !prev_busy) t_start = step_no;
        prev_busy = bus.mem_re || bus.mem_wr;

        // Memory side: serve the access the model expects, or idle with optional stray pulses.
        if (phase == 1) begin
            if (wait_left == 0) begin
                bus.mem_ready = 1'b1;
                if (g_wr) begin
                    bus.mem_data_out = $urandom;
                    mem_model[g_addr] = g_wdata;
                end else begin
                    rdata = mem_read(g_addr);
                    bus.mem_data_out = rdata;
                    if (g_d) m_ddata = rdata;
                    else     m_idata = rdata;
                end
                phase = 2;
            end else begin
                wait_left--;
                bus.mem_ready    = 1'b0;
                bus.mem_data_out = $urandom;
            end
        end else begin
            bus.mem_ready    = spurious_en && ($urandom_range(0, 7) == 0);
            bus.mem_data_out = $urandom;
            if (phase == 2) phase = 0;
        end

        if (old_phase == 2 && !g_d) begin i_active = 1'b0; bus.imem_req = 1'b0; end
        if (old_phase == 2 && g_d)  begin d_active = 1'b0; bus.dmem_req = 1'b0; end
        if (drop_en && old_phase == 1 && !g_d && bus.imem_req && $urandom_range(0, 15) == 0)
            bus.imem_req = 1'b0;
        if (drop_en && old_phase == 1 && g_d && bus.dmem_req && $urandom_range(0, 15) == 0)
            bus.dmem_req = 1'b0;

        if (!i_active) begin
            if (inj_i) begin
                inj_i = 1'b0; t_inj_i = step_no;
                i_active = 1'b1; bus.imem_req = 1'b1; bus.imem_addr = inj_i_addr;
            end else if (hold_both || $urandom_range(0, 99) < i_rate) begin
                i_active = 1'b1; bus.imem_req = 1'b1; bus.imem_addr = rand_addr();
            end
        end
        if (!d_active) begin
            if (inj_d) begin
                inj_d = 1'b0;
                d_active = 1'b1; bus.dmem_req = 1'b1; bus.dmem_wr = inj_d_wr;
                bus.dmem_addr = inj_d_addr; bus.dmem_wdata = inj_d_wdata;
            end else if (hold_both || $urandom_range(0, 99) < d_rate) begin
                d_active = 1'b1; bus.dmem_req = 1'b1;
                bus.dmem_wr = ($urandom_range(0, 99) < wr_rate);
                bus.dmem_addr = rand_addr(); bus.dmem_wdata = $urandom;
            end
        end

        if (old_phase == 0) decide();
    endtask

    task automatic quiesce();
        i_rate = 0; d_rate = 0; hold_both = 1'b0; drop_en = 1'b0; spurious_en = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (phase == 0 && !i_active && !d_active) break;
            step();
        end
        repeat (2) step();
        check_value("quiesce_bus_idle", 32'(bus.mem_re | bus.mem_wr), 32'd0);
    endtask

    task automatic model_reset();
        phase = 0; starve = 0; m_idata = 32'd0; m_ddata = 32'd0;
        g_d = 1'b0; g_wr = 1'b0; g_addr = 32'd0; g_wdata = 32'd0; wait_left = 0;
        prev_busy = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_mem_re"},        32'(bus.mem_re), 32'd0);
        check_value({tag, "_mem_wr"},        32'(bus.mem_wr), 32'd0);
        check_value({tag, "_mem_addr"},      bus.mem_addr, 32'd0);
        check_value({tag, "_mem_data_in"},   bus.mem_data_in, 32'd0);
        check_value({tag, "_imem_ready"},    32'(bus.imem_ready), 32'd0);
        check_value({tag, "_dmem_ready"},    32'(bus.dmem_ready), 32'd0);
        check_value({tag, "_imem_data_out"}, bus.imem_data_out, 32'd0);
        check_value({tag, "_dmem_data_out"}, bus.dmem_data_out, 32'd0);
    endtask

    initial begin
        bus.imem_req = 1'b0; bus.imem_addr = 32'd0;
        bus.dmem_req = 1'b0; bus.dmem_wr = 1'b0; bus.dmem_addr = 32'd0; bus.dmem_wdata = 32'd0;
        bus.mem_data_out = 32'd0; bus.mem_ready = 1'b0;
        i_active = 1'b0; d_active = 1'b0; inj_i = 1'b0; inj_d = 1'b0;
        i_rate = 0; d_rate = 0; wr_rate = 0; max_wait = 0; force_wait = 0; force_en = 1'b1;
        spurious_en = 1'b0; drop_en = 1'b0; hold_both = 1'b0;
        step_no = 0; t_inj_i = 0; t_start = 0; t_iready = 0; t_dready = 0;
        obs_wr_cycles = 0; obs_iready = 0; obs_dready = 0;
        model_reset();

        // Asynchronous reset: outputs must clear before any clock edge.
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait fetch of a known word.
        mem_model[32'h10] = 32'hDEAD_BEEF;
        force_en = 1'b1; force_wait = 0;
        inj_i = 1'b1; inj_i_addr = 32'h0000_0010;
        repeat (6) step();
        check_value("fetch_word", bus.imem_data_out, 32'hDEAD_BEEF);
        check_value("fetch_strobe_latency", 32'(t_start - t_inj_i), 32'd1);
        check_value("fetch_ready_latency", 32'(t_iready - t_inj_i), 32'd2);

        // Store with four memory wait states.
        quiesce();
        force_wait = 4; obs_wr_cycles = 0; obs_dready = 0;
        inj_d = 1'b1; inj_d_wr = 1'b1; inj_d_addr = 32'h100; inj_d_wdata = 32'h1234_5678;
        repeat (10) step();
        check_value("store_wr_cycles", 32'(obs_wr_cycles), 32'd5);
        check_value("store_ready_pulses", 32'(obs_dready), 32'd1);
        force_wait = 0;
        inj_d = 1'b1; inj_d_wr = 1'b0; inj_d_addr = 32'h100; inj_d_wdata = 32'h0;
        repeat (6) step();
        check_value("store_readback", bus.dmem_data_out, 32'h1234_5678);

        // Simultaneous requests: data first, then fetch.
        quiesce();
        inj_i = 1'b1; inj_i_addr = 32'h20;
        inj_d = 1'b1; inj_d_wr = 1'b0; inj_d_addr = 32'h24;
        repeat (8) step();
        check_value("tie_data_first", 32'(t_dready < t_iready), 32'd1);

        // Both requesters held continuously, zero-wait memory.
        quiesce();
        obs_iready = 0; obs_dready = 0;
        hold_both = 1'b1;
        repeat (150) step();
`ifdef ARB_STARVE_GUARD_EN
        check_value("hold_fetch_grants", 32'(obs_iready), 32'd10);
        check_value("hold_data_grants", 32'(obs_dready), 32'd40);
`else
        check_value("hold_fetch_grants", 32'(obs_iready), 32'd0);
        check_value("hold_data_grants", 32'(obs_dready), 32'd50);
`endif

        // Randomised traffic with wait states, stray mem_ready and dropped requests.
        quiesce();
        force_en = 1'b0; max_wait = 4; i_rate = 35; d_rate = 35; wr_rate = 40;
        spurious_en = 1'b1; drop_en = 1'b1;
        repeat (3000) step();

        // Reset during a data access that is waiting on memory.
        quiesce();
        force_en = 1'b1; force_wait = 8;
        inj_d = 1'b1; inj_d_wr = 1'b0; inj_d_addr = 32'h30;
        for (int k = 0; k < 20; k++) begin
            if (phase == 1) break;
            step();
        end
        repeat (2) step();
        check_value("pre_reset_busy", 32'(bus.mem_re), 32'd1);
        #2;
        rst = 1'b1;
        bus.dmem_req = 1'b0; bus.mem_ready = 1'b0;
        bus.imem_req = 1'b1; bus.imem_addr = 32'h44;
        d_active = 1'b0; i_active = 1'b1;
        model_reset();
        #1 check_all_zero("midreset");
        @(posedge clk);
        #1;
        check_value("reset_hold_mem_re", 32'(bus.mem_re), 32'd0);
        check_value("reset_hold_dmem_ready", 32'(bus.dmem_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        force_wait = 0;
        decide();
        repeat (4) step();
        check_value("post_reset_fetch", 32'(t_iready - step_no), 32'(-2));

        quiesce();
        force_en = 1'b0; i_rate = 50; d_rate = 50; wr_rate = 30; spurious_en = 1'b1;
        repeat (500) step();
        quiesce();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
